sr_flag_server: RTL and testbench
=================================

# sr_flag_server

Drains a vector of sticky event flags held in SRFFE latches. Scans the flags round-robin and offers one pending index at a time to a downstream consumer over a req/ack handshake. After acknowledge, issues a one-cycle clear pulse to that flag's SRFFE `r` input and checks that the flag actually dropped. It sits on the read side of SRFFE flag banks: SRFFE `q` feeds `flag`, and `clr` feeds SRFFE `r`.

## Interface
- `W`, default 8: number of flags served.
- `IDXW`, default `W>1 ? $clog2(W) : 1`: index width.
- `CW`, default 8: recurrence counter width.

- `clk`  in  1: clock, rising edge active.
- `clrn`  in  1: reset, asynchronous, active-low.
- `ena`  in  1: permits selection of a new flag; does not abort a transaction in progress.
- `flag`  in  W: sticky flags, normally SRFFE `q`.
- `req`  out  1: offer valid.
- `idx`  out  IDXW: index of the offered flag, stable while `req`=1.
- `ack`  in  1: consumer accepts the offer; ignored while `req`=0.
- `clr`  out  W: one-hot clear pulse, normally SRFFE `r`.
- `busy`  out  1: state ≠ IDLE.
- `recur_cnt`  out  CW: saturating count of clears defeated by a simultaneous set.

## Operation
- All outputs are registered.
- Reset values: `req`=0, `idx`=0, `clr`=0, `busy`=0, `recur_cnt`=0, pointer `ptr`=0, state IDLE.
- FSM states: IDLE → OFFER → CLEAR → SETTLE → IDLE.
- IDLE:
  - Condition: `ena`=1 and |`flag`.
  - Select the first set bit at or above `ptr`, wrapping modulo W.
  - Register `idx`, set `req`=1, go to OFFER.
  - Otherwise stay in IDLE.
- OFFER:
  - Hold `req`=1 and `idx` until `ack`=1 is sampled.
  - Then `req`=0, `clr[idx]`=1, go to CLEAR.
  - `flag[idx]` dropping externally while offered does not withdraw the offer.
- CLEAR: `clr` is high for exactly this one cycle; next state is SETTLE with `clr`=0.
- SETTLE:
  - Sample `flag[idx]`. If it is still 1 (SRFFE set-over-reset priority), increment `recur_cnt`, saturating at 2^CW−1.
  - Always set `ptr` = (`idx`+1) mod W, then go to IDLE.
  - A still-set flag is served again in a later round.
- `ena`=0 only blocks the IDLE→OFFER transition.
- `clrn` low in any state returns everything to reset values immediately. A `clr` pulse may be truncated; a `req` is dropped without handshake.
- Only bits with index < W are ever selected. `idx` never exceeds W−1 for non-power-of-two W.

## Timing
- Flag sampled set in IDLE at edge e0 → `req`/`idx` valid after e0.
- `ack` sampled at edge e1 → `clr` high after e1, low after e2.
- SETTLE evaluated at e3. If another flag is pending, the next `req` rises after e4.
- Acknowledge to next `req` takes at least 3 cycles.
- Minimum service period per flag is 4 cycles with `ack` tied high.
- `ack` held high across transactions is legal; each `req` still lasts at least one cycle.
- Selection is combinational from registered `ptr` and the `flag` input. `flag` must be synchronous to `clk`.

## Structure
- Package `sr_flag_pkg`:
  - state enum `srfs_state_t` {IDLE, OFFER, CLEAR, SETTLE};
  - function computing IDXW from W.
- Sub-module `rr_pick`: combinational round-robin first-set finder.
  - Parameters W, IDXW.
  - Inputs: `vec[W]`, `ptr[IDXW]`.
  - Outputs: `found`, `sel[IDXW]`.
- Top level: FSM, registers, `recur_cnt`.

## Test plan
- Reset: drive `flag`=8'hFF and pulse `clrn` low mid-OFFER → `req`=0, `clr`=0, `busy`=0 within the reset cycle; after release, first `idx`=0.
- Round-robin: `flag`=8'b1001_0010 with `ack` tied high → `idx` sequence 1, 4, 7. Each flag sees a single `clr` pulse one cycle after its `ack` cycle, and the flags go low in turn.
- Wrap: `ptr`=6 with only `flag[2]` set → `idx`=2; afterwards `ptr`=3.
- Simultaneous set: assert SRFFE `s[3]` in the CLEAR cycle for flag 3 → `flag[3]` remains 1, `recur_cnt` goes 0→1, flag 3 is offered again. After 300 such events, `recur_cnt`=255.
- Enable: `ena`=0 with `flag`≠0 → `req` stays 0. Drop `ena` during OFFER → the transaction still completes through SETTLE and no new `req` appears.
- Handshake: hold `ack`=0 for 10 cycles → `req` and `idx` stay stable and `clr` stays 0. Pulse `ack` while `req`=0 → no effect.

Source files
------------

// File: rtl/sr_flag_pkg.sv
// Shared types and helpers for the sticky-flag server.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    CLEAR  = 2'd2,
    SETTLE = 2'd3
  } srfs_state_t;

  // Index width for a bank of w flags; a single flag still needs one bit.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sr_flag_server_if.sv
// Offer channel between the flag server and its downstream consumer.
//
// Handshake: req is the offer-valid, idx the payload. Once req rises, req and
// idx stay stable until ack is sampled high on a rising clk edge; that edge
// completes the transfer and req drops on the next cycle. ack is ignored
// while req is low and may be held high across transfers.
interface sr_flag_server_if #(
  parameter int IDXW = 3
);
  logic            req;
  logic [IDXW-1:0] idx;
  logic            ack;

  modport master (output req, output idx, input ack);
  modport slave  (input req, input idx, output ack);
endinterface

// File: rtl/sr_flag_server_rr_pick.sv
// Combinational round-robin finder: first set bit at or above ptr, wrapping.
module rr_pick #(
  parameter int W    = 8,
  parameter int IDXW = 3
) (
  input  logic [W-1:0]    vec,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] sel
);

  // Walk downward so the candidate closest to ptr is written last and wins.
  always_comb begin
    int              j;
    logic [IDXW-1:0] pos;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    pos   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= W) j = j - W;
      pos = IDXW'(j);
      if (vec[pos]) begin
        found = 1'b1;
        sel   = pos;
      end
    end
  end

endmodule

// File: rtl/sr_flag_server.sv
// Round-robin server for a bank of SRFFE sticky flags: offers one pending
// index at a time, pulses its clear after acknowledge and counts clears
// that were defeated by a simultaneous set.
module sr_flag_server
  import sr_flag_pkg::*;
#(
  parameter int W    = 8,
  parameter int IDXW = idx_width(W),
  parameter int CW   = 8
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                ena,
  input  logic [W-1:0]        flag,
  sr_flag_server_if.master    link,
  output logic [W-1:0]        clr,
  output logic                busy,
  output logic [CW-1:0]       recur_cnt,
  output srfs_state_t         state
);

  srfs_state_t     state_q, state_d;
  logic            found;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] ptr_next;
  logic            req_q;

  rr_pick #(.W(W), .IDXW(IDXW)) u_pick (
    .vec   (flag),
    .ptr   (ptr),
    .found (found),
    .sel   (sel)
  );

  assign link.req = req_q;
  assign link.idx = idx_q;
  assign state    = state_q;
  assign ptr_next = (int'(idx_q) == W - 1) ? '0 : idx_q + IDXW'(1);

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ena only gates the start of a new transaction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ena && found) state_d = OFFER;
      OFFER:   if (link.ack)     state_d = CLEAR;
      CLEAR:                     state_d = SETTLE;
      SETTLE:                    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Registered outputs, pointer and recurrence counter, derived from the transition.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      req_q     <= 1'b0;
      idx_q     <= '0;
      clr       <= '0;
      busy      <= 1'b0;
      recur_cnt <= '0;
      ptr       <= '0;
    end else begin
      req_q <= (state_d == OFFER);
      busy  <= (state_d != IDLE);
      clr   <= '0;
      if (state_q == IDLE && state_d == OFFER) idx_q <= sel;
      if (state_q == OFFER && link.ack) clr <= W'(1) << idx_q;
      if (state_q == SETTLE) begin
        ptr <= ptr_next;
        // A flag still high here was re-set while its clear was applied.
        if (flag[idx_q] && recur_cnt != '1) recur_cnt <= recur_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sr_flag_server.sv
// Bench for sr_flag_server with an SRFFE bank model (set over reset).
module tb_sr_flag_server;
  import sr_flag_pkg::*;

  localparam int W    = 8;
  localparam int IDXW = 3;
  localparam int CW   = 8;

  logic            clk  = 1'b0;
  logic            clrn = 1'b0;
  logic            ena  = 1'b0;
  logic [W-1:0]    flag = '0;
  logic [W-1:0]    s    = '0;
  logic [W-1:0]    clr;
  logic            busy;
  logic [CW-1:0]   recur_cnt;
  srfs_state_t     dbg_state;

  sr_flag_server_if #(.IDXW(IDXW)) link ();

  sr_flag_server #(.W(W), .IDXW(IDXW), .CW(CW)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ena       (ena),
    .flag      (flag),
    .link      (link),
    .clr       (clr),
    .busy      (busy),
    .recur_cnt (recur_cnt),
    .state     (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // SRFFE bank: set wins over reset.
  always @(posedge clk) flag <= s | (flag & ~clr);

  int              n_vec = 0;
  int              n_err = 0;
  logic [IDXW-1:0] exp_q[$];
  logic [W-1:0]    pend_clr = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: pop on each accepted offer; expect its clear pulse next cycle.
  always @(negedge clk) begin
    if (!clrn) begin
      pend_clr <= '0;
    end else begin
      check("clr", 32'(clr), 32'(pend_clr));
      if (link.req && link.ack) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("idx", 32'(link.idx), 32'(exp_q.pop_front()));
        pend_clr <= W'(1) << link.idx;
      end else begin
        pend_clr <= '0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_flags(input logic [W-1:0] v);
    s = v;
    tick(1);
    s = '0;
  endtask

  task automatic wait_req(input int max);
    int k;
    k = 0;
    while (!link.req && k < max) begin
      tick(1);
      k++;
    end
    check("req_seen", 32'(link.req), 32'd1);
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((flag != '0 || busy || exp_q.size() != 0) && k < max) begin
      tick(1);
      k++;
    end
    check("drain", 32'({flag != '0, busy, exp_q.size() != 0}), 32'd0);
  endtask

  // Re-set flag 3 during its clear cycle so the clear is defeated.
  task automatic defeat3();
    int k;
    k = 0;
    while (!clr[3] && k < 20) begin
      tick(1);
      k++;
    end
    check("clr3_seen", 32'(clr[3]), 32'd1);
    s = 8'h08;
    tick(1);
    s = '0;
  endtask

  task automatic push(input logic [IDXW-1:0] v);
    exp_q.push_back(v);
  endtask

  initial begin
    int k;
    link.ack = 1'b0;

    // Reset values.
    #12;
    check("rst_req", 32'(link.req), 32'd0);
    check("rst_idx", 32'(link.idx), 32'd0);
    check("rst_clr", 32'(clr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_recur", 32'(recur_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    tick(1);
    clrn = 1'b1;
    ena  = 1'b1;

    // Reset asserted in the middle of an offer.
    set_flags(8'hFF);
    wait_req(10);
    check("offer_idx0", 32'(link.idx), 32'd0);
    tick(2);
    #3 clrn = 1'b0;
    #1;
    check("midrst_req", 32'(link.req), 32'd0);
    check("midrst_clr", 32'(clr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tick(1);
    clrn = 1'b1;
    wait_req(10);
    check("post_rst_idx", 32'(link.idx), 32'd0);

    // ack held low: offer holds steady.
    repeat (10) begin
      tick(1);
      check("hold_req", 32'(link.req), 32'd1);
      check("hold_idx", 32'(link.idx), 32'd0);
    end
    for (int i = 0; i < W; i++) push(IDXW'(i));
    link.ack = 1'b1;
    drain(100);

    // ack pulse with nothing offered.
    link.ack = 1'b0;
    tick(1);
    link.ack = 1'b1;
    tick(1);
    link.ack = 1'b0;
    tick(1);
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_req", 32'(link.req), 32'd0);
    link.ack = 1'b1;

    // Round robin, ack tied high.
    push(3'd1); push(3'd4); push(3'd7);
    set_flags(8'b1001_0010);
    drain(100);

    // Wrap: ptr 6 after serving 5, then only flag 2, then 1 and 3 from ptr 3.
    push(3'd5);
    set_flags(8'h20);
    drain(50);
    push(3'd2);
    set_flags(8'h04);
    drain(50);
    push(3'd3); push(3'd1);
    set_flags(8'h0A);
    drain(50);

    // Clear defeated by a simultaneous set.
    check("recur_0", 32'(recur_cnt), 32'd0);
    push(3'd3); push(3'd3);
    set_flags(8'h08);
    defeat3();
    drain(50);
    check("recur_1", 32'(recur_cnt), 32'd1);
    for (int i = 0; i < 301; i++) push(3'd3);
    set_flags(8'h08);
    repeat (300) defeat3();
    drain(100);
    check("recur_sat", 32'(recur_cnt), 32'd255);

    // Enable low blocks new offers.
    ena = 1'b0;
    set_flags(8'h40);
    repeat (8) begin
      tick(1);
      check("ena0_req", 32'(link.req), 32'd0);
    end
    link.ack = 1'b0;
    ena = 1'b1;
    push(3'd6);
    wait_req(10);
    set_flags(8'h01);
    ena = 1'b0;
    link.ack = 1'b1;
    k = 0;
    while (busy && k < 20) begin
      tick(1);
      k++;
    end
    check("ena_drop_done", 32'(busy), 32'd0);
    repeat (6) begin
      tick(1);
      check("ena_drop_req", 32'(link.req), 32'd0);
    end
    push(3'd0);
    ena = 1'b1;
    drain(50);

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
